// File: rtl/wb_dest_tracker_pkg.sv
// Shared pipeline definitions: forward selects, register constants and the
// EX/MEM destination payload.
package wb_dest_tracker_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_PIPE = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             we;
        logic             load;
    } mem_stage_t;

    // A tracked write matches a source only when it is enabled and never for $0.
    function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                     input logic             we,
                                     input logic [REG_W-1:0] src);
        return we && (dst == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_dest_tracker_fwd_compare.sv
// EX operand forward select for one source register; MEM wins over WB and a
// load still in MEM has no data to forward yet.
module fwd_compare
    import wb_dest_tracker_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  mem_stage_t       mem_stage,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_we,
    output logic [FWD_W-1:0] sel_c
);

    always_comb begin
        sel_c = FWD_PIPE;
        if (reg_hit(mem_stage.dst, mem_stage.we & ~mem_stage.load, src)) begin
            sel_c = FWD_MEM;
        end else if (reg_hit(wb_dst, wb_we, src)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/wb_dest_tracker.sv
// Tracks the write-back destination through EX/MEM and MEM/WB and derives
// forwarding selects, the WB->ID bypass and the load-use stall request.
module wb_dest_tracker
    import wb_dest_tracker_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic             ex_flush,
    input  logic             hold,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             load_use_stall,
    output logic [REG_W-1:0] wb_dst,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mem_stage_t mem_q;
    mem_stage_t mem_d;

    // A flushed instruction enters MEM as a bubble; $0 never carries a write.
    always_comb begin
        mem_d      = '0;
        mem_d.dst  = ex_dst;
        mem_d.we   = ex_we & ~ex_flush & (ex_dst != REG_ZERO);
        mem_d.load = ex_load & ~ex_flush;
    end

    // EX/MEM and MEM/WB destination registers, frozen together by hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wb_dst <= REG_ZERO;
            wb_we  <= 1'b0;
        end else if (!hold) begin
            mem_q  <= mem_d;
            wb_dst <= mem_q.dst;
            wb_we  <= mem_q.we;
        end
    end

    fwd_compare u_fwd_rs (
        .src       (ex_rs),
        .mem_stage (mem_q),
        .wb_dst    (wb_dst),
        .wb_we     (wb_we),
        .sel_c     (fwd_a)
    );

    fwd_compare u_fwd_rt (
        .src       (ex_rt),
        .mem_stage (mem_q),
        .wb_dst    (wb_dst),
        .wb_we     (wb_we),
        .sel_c     (fwd_b)
    );

    // Register file is read in ID while WB writes the same entry.
    always_comb begin
        id_byp_a = reg_hit(wb_dst, wb_we, id_rs);
        id_byp_b = reg_hit(wb_dst, wb_we, id_rt);
    end

    always_comb begin
        load_use_stall = 1'b0;
        if (ex_load && ex_we && !ex_flush && (ex_dst != REG_ZERO)) begin
            load_use_stall = (ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt));
        end
    end

    // Saturating count of stall cycles that actually took effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (load_use_stall && !hold && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Directed bench for wb_dest_tracker: a vector table for the combinational
// selects against a frozen pipeline, plus hand-written multi-cycle sequences.
module tb_wb_dest_tracker;

    logic       clk;
    logic       rst_n;
    logic [4:0] ex_dst;
    logic       ex_we;
    logic       ex_load;
    logic       ex_flush;
    logic       hold;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;

    logic [1:0]  fwd_a, fwd_b;
    logic        id_byp_a, id_byp_b, load_use_stall, wb_we;
    logic [4:0]  wb_dst;
    logic [15:0] stall_count;

    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_byp_a, s_byp_b, s_stall, s_wb_we;
    logic [4:0]  s_wb_dst;
    logic [1:0]  s_stall_count;

    int checks   = 0;
    int failures = 0;

    wb_dest_tracker #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load),
        .ex_flush(ex_flush), .hold(hold), .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .load_use_stall(load_use_stall),
        .wb_dst(wb_dst), .wb_we(wb_we), .stall_count(stall_count)
    );

    wb_dest_tracker #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load),
        .ex_flush(ex_flush), .hold(hold), .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .id_byp_a(s_byp_a), .id_byp_b(s_byp_b), .load_use_stall(s_stall),
        .wb_dst(s_wb_dst), .wb_we(s_wb_we), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] ex_dst;
        logic       ex_we;
        logic       ex_load;
        logic       ex_flush;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic [1:0] exp_fwd_a;
        logic [1:0] exp_fwd_b;
        logic       exp_byp_a;
        logic       exp_byp_b;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_dst = 5'd0; ex_we = 1'b0; ex_load = 1'b0; ex_flush = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dst, input logic we, input logic load);
        clear_in();
        ex_dst = dst; ex_we = we; ex_load = load;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Pipeline state for the table: MEM = load to $12, WB = ALU write to $9.
        //                 name            dst  we  ld  fl  ex_rs ex_rt id_rs id_rt use fa     fb     ba  bb  st
        vecs[0] = '{"wb_rs",         5'd0,  0, 0, 0, 5'd9,  5'd12, 5'd0,  5'd0,  0, 2'b01, 2'b00, 0, 0, 0};
        vecs[1] = '{"zero_src",      5'd0,  0, 0, 0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[2] = '{"rt_wb_byp",     5'd0,  0, 0, 0, 5'd5,  5'd9,  5'd9,  5'd9,  0, 2'b00, 2'b01, 1, 1, 0};
        vecs[3] = '{"lu_rs",         5'd10, 1, 1, 0, 5'd0,  5'd0,  5'd10, 5'd0,  0, 2'b00, 2'b00, 0, 0, 1};
        vecs[4] = '{"lu_flush",      5'd10, 1, 1, 1, 5'd0,  5'd0,  5'd10, 5'd0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[5] = '{"lu_dst0",       5'd0,  1, 1, 0, 5'd0,  5'd0,  5'd0,  5'd0,  1, 2'b00, 2'b00, 0, 0, 0};
        vecs[6] = '{"lu_rt_unused",  5'd10, 1, 1, 0, 5'd0,  5'd0,  5'd3,  5'd10, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[7] = '{"lu_rt_used",    5'd10, 1, 1, 0, 5'd12, 5'd0,  5'd3,  5'd10, 1, 2'b00, 2'b00, 0, 0, 1};
        vecs[8] = '{"lu_no_we",      5'd10, 0, 1, 0, 5'd0,  5'd0,  5'd10, 5'd0,  0, 2'b00, 2'b00, 0, 0, 0};
        vecs[9] = '{"byp_rs0",       5'd0,  0, 0, 0, 5'd0,  5'd12, 5'd0,  5'd9,  0, 2'b00, 2'b00, 0, 1, 0};

        clear_in();
        hold  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;

        // Back-to-back ALU dependency: add $8 then sub reading $8.
        issue(5'd8, 1, 0);
        tick();
        issue(5'd11, 1, 0);
        ex_rs = 5'd8;
        #1;
        chk("b2b_fwd_mem", 32'(fwd_a), 32'b10);
        chk("b2b_wb_we_early", 32'(wb_we), 32'd0);
        tick();
        clear_in();
        ex_rs = 5'd8;
        #1;
        chk("b2b_fwd_wb", 32'(fwd_a), 32'b01);
        chk("b2b_wb_dst", 32'(wb_dst), 32'd8);
        chk("b2b_wb_we", 32'(wb_we), 32'd1);
        tick();

        // Same destination in MEM and WB: MEM wins unless it is a load.
        issue(5'd9, 1, 0);
        tick();
        issue(5'd9, 1, 0);
        tick();
        clear_in();
        ex_rt = 5'd9;
        #1;
        chk("dbl_fwd_mem", 32'(fwd_b), 32'b10);
        issue(5'd9, 1, 1);
        tick();
        clear_in();
        ex_rt = 5'd9;
        #1;
        chk("dbl_load_fwd_wb", 32'(fwd_b), 32'b01);

        // Table vectors against a held pipeline.
        issue(5'd9, 1, 0);
        tick();
        issue(5'd12, 1, 1);
        tick();
        clear_in();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ex_dst = vecs[i].ex_dst; ex_we = vecs[i].ex_we; ex_load = vecs[i].ex_load;
            ex_flush = vecs[i].ex_flush; ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].id_uses_rt;
            #1;
            chk({vecs[i].name, "_fwd_a"}, 32'(fwd_a), 32'(vecs[i].exp_fwd_a));
            chk({vecs[i].name, "_fwd_b"}, 32'(fwd_b), 32'(vecs[i].exp_fwd_b));
            chk({vecs[i].name, "_byp_a"}, 32'(id_byp_a), 32'(vecs[i].exp_byp_a));
            chk({vecs[i].name, "_byp_b"}, 32'(id_byp_b), 32'(vecs[i].exp_byp_b));
            chk({vecs[i].name, "_stall"}, 32'(load_use_stall), 32'(vecs[i].exp_stall));
        end
        clear_in();
        #1;
        hold = 1'b0;
        tick();

        // Load-use stall counting, then flush and $0 suppress it.
        chk("lu_count0", 32'(stall_count), 32'd0);
        issue(5'd10, 1, 1);
        id_rs = 5'd10;
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        chk("lu_count1", 32'(stall_count), 32'd1);
        ex_flush = 1'b1;
        #1;
        chk("lu_flush_stall", 32'(load_use_stall), 32'd0);
        tick();
        ex_flush = 1'b0;
        ex_dst   = 5'd0;
        id_rs    = 5'd0;
        #1;
        chk("lu_dst0_stall", 32'(load_use_stall), 32'd0);
        tick();
        chk("lu_count_kept", 32'(stall_count), 32'd1);

        // Asynchronous reset in mid-stream with live writes in MEM and WB.
        issue(5'd3, 1, 0);
        tick();
        issue(5'd4, 1, 0);
        tick();
        clear_in();
        ex_rs = 5'd4; ex_rt = 5'd3; id_rs = 5'd3;
        #1;
        chk("pre_rst_fwd_a", 32'(fwd_a), 32'b10);
        chk("pre_rst_fwd_b", 32'(fwd_b), 32'b01);
        chk("pre_rst_byp_a", 32'(id_byp_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_we", 32'(wb_we), 32'd0);
        chk("mid_rst_wb_dst", 32'(wb_dst), 32'd0);
        chk("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("mid_rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("mid_rst_byp_a", 32'(id_byp_a), 32'd0);
        chk("mid_rst_count", 32'(stall_count), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_in();

        // Hold for three cycles with jal ($31) waiting in EX.
        issue(5'd7, 1, 0);
        tick();
        clear_in();
        tick();
        issue(5'd31, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_flush = (i == 1);
            #1;
            chk("hold_wb_dst", 32'(wb_dst), 32'd7);
            chk("hold_wb_we", 32'(wb_we), 32'd1);
            tick();
        end
        hold     = 1'b0;
        ex_flush = 1'b0;
        tick();
        chk("rel1_wb_we", 32'(wb_we), 32'd0);
        clear_in();
        tick();
        chk("rel2_wb_dst", 32'(wb_dst), 32'd31);
        chk("rel2_wb_we", 32'(wb_we), 32'd1);

        // Writes to $0 are dropped and never forwarded.
        issue(5'd0, 1, 0);
        tick();
        clear_in();
        #1;
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        tick();
        chk("r0_wb_we", 32'(wb_we), 32'd0);

        // Four stall cycles saturate the 2-bit counter at 3.
        chk("sat_start", 32'(s_stall_count), 32'd0);
        issue(5'd10, 1, 1);
        id_rs = 5'd10;
        repeat (4) tick();
        clear_in();
        chk("sat_small", 32'(s_stall_count), 32'd3);
        chk("sat_main", 32'(stall_count), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dest_tracker.md
# wb_dest_tracker

Carries the write-back destination register number (the 5-bit result of the rt/rd/$31 destination select in EX) through the EX/MEM and MEM/WB pipeline registers. Drives the register-file write port in WB. From the tracked destinations it generates EX-stage operand-forwarding selects, the WB→ID register-file bypass, and the load-use stall request. It sits between the EX-stage destination mux and the register file / hazard control of the 5-stage MIPS pipeline.

## Interface
- Parameters:
- `CNT_W`, default 16: width of the saturating load-use stall counter.
- Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_dst` in 5: destination register of the instruction in EX (destination-mux output).
- `ex_we` in 1: EX instruction writes a register.
- `ex_load` in 1: EX instruction is a load (lw).
- `ex_flush` in 1: kill the EX instruction as it advances.
- `hold` in 1: freeze the MEM and WB stages (memory wait).
- `ex_rs`, `ex_rt` in 5 each: source registers of the instruction in EX.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt as a source.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 00 = pipeline value, 01 = WB result, 10 = MEM ALU result.
- `id_byp_a`, `id_byp_b` out 1 each: ID read of rs/rt takes the WB write data.
- `load_use_stall` out 1: stall IF/ID and insert a bubble into EX.
- `wb_dst` out 5: register-file write address.
- `wb_we` out 1: register-file write enable.
- `stall_count` out CNT_W: number of load-use stall cycles, saturating.

## Operation
- Internal registers: `mem_dst`, `mem_we`, `mem_load` (EX/MEM), and `wb_dst`, `wb_we` (MEM/WB).
- Advance when `hold`=0:
  - MEM captures `ex_dst`, `ex_we & ~ex_flush & (ex_dst≠0)`, and `ex_load & ~ex_flush`.
  - WB captures the MEM values.
- When `hold`=1: all tracked registers keep their values and `ex_flush` is ignored.
- Register $0 is never written and never forwarded. A write enable is cleared whenever the destination is 0.
- `fwd_a` (same rule for `fwd_b` using `ex_rt`):
  - 10 if `mem_we & ~mem_load & mem_dst==ex_rs`;
  - else 01 if `wb_we & wb_dst==ex_rs`;
  - else 00.
  - MEM takes priority over WB.
  - A load in MEM is never forwarded from MEM.
- `id_byp_a` = `wb_we & wb_dst==id_rs & id_rs≠0`. `id_byp_b` is the same rule using `id_rt`.
- `load_use_stall` = `ex_load & ex_we & ~ex_flush & ex_dst≠0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt))`.
- The upstream ID/EX register inserts the bubble in response to `load_use_stall`. This block does not gate its own inputs on it.
- `stall_count` increments on each clock edge where `load_use_stall`=1 and `hold`=0. It saturates at all-ones.
- Asynchronous reset (`rst_n`=0), effective immediately and mid-operation:
  - `mem_*`, `wb_dst`, `wb_we` = 0;
  - `stall_count` = 0;
  - therefore `fwd_a`, `fwd_b` = 00 and `id_byp_*` = 0.
  - `load_use_stall` remains a combinational function of the EX/ID inputs.

## Timing
- All forwarding, bypass and stall outputs are combinational from the current registers and inputs. They are valid in the same cycle.
- Latency: an EX destination appears on `wb_dst`/`wb_we` exactly 2 un-held cycles later.
- `hold` stretches that latency by one cycle per held cycle. `wb_we` stays asserted during hold; the register-file write is idempotent.
- Flush and load in the same cycle: flush wins, so no stall and no write.
- The same destination in MEM and WB: MEM is selected (youngest value).

## Structure
- Shared pipeline package holds:
  - forward-select constants `FWD_PIPE`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - register constants `REG_ZERO`=5'd0 and `REG_RA`=5'd31.
- One natural sub-module, `fwd_compare`. It takes one source register plus the MEM/WB state and returns a 2-bit select. It is instantiated twice, for rs and rt.

## Test plan
- Reset mid-stream: with `mem_we`=`wb_we`=1, pull `rst_n` low asynchronously.
  - Expected: `wb_we`=0, `fwd_a`=`fwd_b`=00, `stall_count`=0 before the next clock edge.
- Back-to-back ALU dependency: `add $8` then `sub` reading `$8` as rs.
  - Expected: `fwd_a`=10 for one cycle. `wb_dst`=8 and `wb_we`=1 two cycles after the add was in EX.
- Double hit: `$9` in both MEM and WB, `ex_rt`=9.
  - Expected: `fwd_b`=10.
  - Same case with the MEM instruction being a load: `fwd_b`=01.
- Load-use stall: `ex_load`=1, `ex_dst`=10, `id_rs`=10.
  - Expected: `load_use_stall`=1 and `stall_count` goes 0→1.
  - Same case with `ex_flush`=1: `load_use_stall`=0.
  - Same case with `ex_dst`=0: `load_use_stall`=0.
- Hold: assert `hold` for 3 cycles with `ex_we`=1, `ex_dst`=31 (jal).
  - Expected: `wb_dst` is unchanged during the hold and becomes 31 two cycles after release.
  - `ex_flush` pulsed during the hold has no effect.
- Register $0: `ex_we`=1, `ex_dst`=0, then `ex_rs`=0.
  - Expected: `fwd_a`=00 and `wb_we` stays 0.
  - With `CNT_W`=2, four consecutive stall cycles leave `stall_count`=3.
